// File: rtl/run_detector_pkg.sv
// Shared mode encodings and polarity match helper for the run detector.
package run_detector_pkg;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_ANY  = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  function automatic logic match_mode(input logic b, input logic [1:0] mode);
    logic m;
    case (mode)
      MODE_ZERO: m = (b == 1'b0);
      MODE_ONE:  m = (b == 1'b1);
      MODE_ANY:  m = 1'b1;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one, used for both
// the run length and the detection count.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clr)
      w_count_next = '0;
    else if (i_load)
      w_count_next = WIDTH'(1);
    else if (i_inc && (r_count != MAX))
      w_count_next = r_count + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_count <= '0;
    else
      r_count <= w_count_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_detector.sv
// Tracks the current run of identical valid samples and flags/counts runs that
// reach RUN_LEN for the polarity selected by mode.
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int DET_W   = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic                             in,
  input  logic [1:0]                       mode,
  output logic                             out,
  output logic                             run_bit,
  output logic [$clog2(RUN_LEN+1)-1:0]     run_cnt,
  output logic                             det_pulse,
  output logic [DET_W-1:0]                 det_count
);

  localparam int                CNT_W   = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0]  CNT_PRE = CNT_W'(RUN_LEN - 1);

  if ((RUN_LEN < 2) || (RUN_LEN > 255)) begin : g_bad_run_len
    $error("run_detector: RUN_LEN must be in 2..255");
  end

  logic                r_run_bit;
  logic                r_out;
  logic                r_det_pulse;
  logic [CNT_W-1:0]    w_run_cnt;
  logic                w_new_run;
  logic                w_cont;
  logic                w_run_bit_next;
  logic                w_at_max_next;
  logic                w_match_next;
  logic                w_det_next;

  // A sample starts a new run when nothing is tracked yet or the bit flips.
  assign w_new_run      = in_valid && ((w_run_cnt == '0) || (in != r_run_bit));
  assign w_cont         = in_valid && !w_new_run;
  assign w_run_bit_next = clear ? 1'b0 : (w_new_run ? in : r_run_bit);
  assign w_match_next   = match_mode(w_run_bit_next, mode);

  // A new run always restarts at 1, which can never equal RUN_LEN (>= 2).
  assign w_at_max_next  = !clear && !w_new_run &&
                          ((w_run_cnt == CNT_MAX) || (in_valid && (w_run_cnt == CNT_PRE)));
  assign w_det_next     = !clear && w_cont && (w_run_cnt == CNT_PRE) && w_match_next;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (CNT_MAX)
  ) u_run_cnt (
    .clk     (clk),
    .i_rst_n (reset_n),
    .i_clr   (clear),
    .i_load  (w_new_run),
    .i_inc   (w_cont),
    .o_count (w_run_cnt)
  );

  sat_counter #(
    .WIDTH (DET_W)
  ) u_det_cnt (
    .clk     (clk),
    .i_rst_n (reset_n),
    .i_clr   (clear),
    .i_load  (1'b0),
    .i_inc   (w_det_next),
    .o_count (det_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_bit   <= 1'b0;
      r_out       <= 1'b0;
      r_det_pulse <= 1'b0;
    end else begin
      r_run_bit   <= w_run_bit_next;
      r_out       <= w_at_max_next && w_match_next;
      r_det_pulse <= w_det_next;
    end
  end

  assign out       = r_out;
  assign run_bit   = r_run_bit;
  assign run_cnt   = w_run_cnt;
  assign det_pulse = r_det_pulse;

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the fixed 4-in-a-row sequence detector FSM.
- Watches a 1-bit sample stream qualified by a valid strobe and tracks the current run of identical bits with a saturating counter.
- Flags when the run reaches RUN_LEN for a selectable polarity, and counts detection events.
- Sits in the test7 FSM family as the reusable detector that replaces the hard-coded 9-state machine.

Parameters:
- RUN_LEN, 4, run length that triggers detection; legal range 2..255 (elaboration error outside this range).
- DET_W, 8, width of the detection-event counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of run state, out and det_count.
- in_valid  input  1  in is sampled this cycle.
- in  input  1  stream bit.
- mode  input  2  00 = detect runs of 0, 01 = runs of 1, 10 = either polarity, 11 = disabled.
- out  output  1  registered; high while the current run is at least RUN_LEN and the polarity matches mode.
- run_bit  output  1  value of the current run.
- run_cnt  output  $clog2(RUN_LEN+1)  current run length, saturating at RUN_LEN.
- det_pulse  output  1  one-cycle pulse per new detection.
- det_count  output  DET_W  number of detections, saturating at all-ones.

Behaviour:
- Reset (reset_n low, asynchronous): out=0, run_bit=0, run_cnt=0, det_pulse=0, det_count=0. Deassertion is taken synchronously by the next edge.
- Priority at each rising edge: reset_n, then clear, then in_valid.
- clear=1:
  - run_cnt=0, run_bit=0, out=0, det_pulse=0, det_count=0.
  - A simultaneous in_valid sample is discarded.
- in_valid=1, clear=0:
  - If run_cnt==0 or in!=run_bit: run_bit<=in, run_cnt<=1.
  - Else run_cnt<=min(run_cnt+1, RUN_LEN). It stays at RUN_LEN for longer runs.
- in_valid=0: run_bit and run_cnt hold.
- match(b, mode):
  - mode 00: b==0.
  - mode 01: b==1.
  - mode 10: always true.
  - mode 11: never true.
- out is registered every cycle as (run_cnt_next==RUN_LEN) && match(run_bit_next, mode).
  - Moore behaviour: the sample accepted at edge N is reflected in out after edge N. This is one cycle after the sample is presented, matching the original FSM latency.
  - A mode change is reflected in out one edge later, even with no valid sample.
- det_pulse is registered and goes high for exactly one cycle when both hold:
  - An accepted sample moves run_cnt from RUN_LEN-1 to RUN_LEN.
  - match(run_bit_next, mode) is true.
  - Otherwise det_pulse is 0.
- A saturated run continuing produces no further pulses.
- A mode change that raises out does not pulse.
- det_count increments with each det_pulse and saturates at 2^DET_W-1 (no wrap).
- Polarity flip at saturation:
  - run_cnt drops to 1 and out falls on the same edge.
  - A new run of RUN_LEN opposite bits gives a new pulse, provided mode allows that polarity.
- Gaps (in_valid low) never break a run.

Decomposition:
- Package run_detector_pkg holds the mode constants: MODE_ZERO=2'b00, MODE_ONE=2'b01, MODE_ANY=2'b10, MODE_OFF=2'b11.
- The package also holds the function match_mode(bit, mode).
- One natural sub-module, sat_counter (parametrised WIDTH and MAX; inc, clr, asynchronous active-low reset). It is used for both run_cnt and det_count.
- The remaining logic sits flat in run_detector.

Test Plan:
- Reset/basic: reset_n=0 mid-run -> all outputs 0 immediately. Release, mode=10, feed 0,0,0,0 with valid every cycle -> run_cnt 1,2,3,4; out=1 and det_pulse=1 after the 4th edge; det_count=1.
- Continuation and flip: after the previous scenario, feed four more 0s -> out stays 1, no pulse, run_cnt=4. Then feed 1 -> out=0, run_bit=1, run_cnt=1. Then three more 1s -> pulse; det_count=2.
- Mode filter: mode=01, feed 0×6 -> out=0, no pulse. Switch to mode=00 with in_valid=0 -> out=1 one edge later, det_pulse stays 0.
- Valid gaps and clear: RUN_LEN=6, feed 1,1,_,_,1,1,1,1 with in_valid low on the gaps -> single pulse on the 6th valid sample. Assert clear together with in_valid -> run_cnt=0, det_count=0, sample dropped.
- Saturation: DET_W=2, mode=10, alternate runs of RUN_LEN 0s and 1s for 5 runs -> det_count reads 1,2,3,3,3.
- Disabled mode: mode=11, any stream -> out=0 and det_pulse=0, while run_cnt still tracks the stream.
